// File: rtl/cwadd_pkg.sv
// Shared CWADD datapath definitions: FSM encoding and BCD digit constants.
// Used by the BCD-to-binary converter and its digit correction cell.
package cwadd_pkg;

    localparam int BCD_DIGIT_W = 4;
    localparam logic [BCD_DIGIT_W-1:0] BCD_CORR = 4'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic digit_invalid(input logic [BCD_DIGIT_W-1:0] d);
        return d > 4'd9;
    endfunction

endpackage

// File: rtl/bcd_to_bin_seq_if.sv
// Start/busy/done handshake bundle for the sequential BCD-to-binary converter.
interface bcd_to_bin_seq_if #(
    parameter int NDIG = 3,
    parameter int BW   = 8
) ();
    logic              start;
    logic [4*NDIG-1:0] bcd_in;
    logic              busy;
    logic              done;
    logic [BW-1:0]     bin_out;
    logic              bad_digit;
    logic              ovf;

    modport master (
        output start, bcd_in,
        input  busy, done, bin_out, bad_digit, ovf
    );

    modport slave (
        input  start, bcd_in,
        output busy, done, bin_out, bad_digit, ovf
    );
endinterface

// File: rtl/bcd_digit_sub3.sv
// Reverse double-dabble correction for one BCD digit: subtract 3 when the
// digit is 8 or more after the right shift.
module bcd_digit_sub3
    import cwadd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] d,
    output logic [BCD_DIGIT_W-1:0] q
);
    assign q = (d >= 4'd8) ? d - BCD_CORR : d;
endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter using reverse double-dabble, one shift
// per clock for BW clocks, with invalid-digit and overflow flags.
module bcd_to_bin_seq
    import cwadd_pkg::*;
#(
    parameter int NDIG = 3,
    parameter int BW   = 8
) (
    input  logic               clk,
    input  logic               rst,
    bcd_to_bin_seq_if.slave    bus
);
    localparam int DW = BCD_DIGIT_W * NDIG;
    localparam int CW = $clog2(BW + 1);

    state_t            state_reg, state_next;
    logic [DW-1:0]     bcd_reg;
    logic [DW-1:0]     bcd_corr;
    logic [BW-1:0]     bin_reg;
    logic [BW-1:0]     bin_shift;
    logic [CW-1:0]     cnt_reg;
    logic              bad_flag_reg;
    logic [BW-1:0]     bin_out_reg;
    logic              bad_digit_reg;
    logic              ovf_reg;
    logic [DW+BW-1:0]  shifted;
    logic [NDIG-1:0]   digit_bad_vec;
    logic              accept;
    logic              last_shift;

    assign shifted   = {bcd_reg, bin_reg} >> 1;
    assign bin_shift = shifted[BW-1:0];

    generate
        for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
            bcd_digit_sub3 u_sub3 (
                .d (shifted[BW + gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .q (bcd_corr[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
            );
            assign digit_bad_vec[gi] = digit_invalid(bus.bcd_in[gi*BCD_DIGIT_W +: BCD_DIGIT_W]);
        end
    endgenerate

    // DONE also accepts, so start held high gives back-to-back conversions.
    assign accept     = bus.start && (state_reg != ST_SHIFT);
    assign last_shift = (state_reg == ST_SHIFT) && (cnt_reg == CW'(BW - 1));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (accept) state_next = ST_SHIFT;
            ST_SHIFT: if (last_shift) state_next = ST_DONE;
            ST_DONE:  state_next = accept ? ST_SHIFT : ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            bcd_reg       <= '0;
            bin_reg       <= '0;
            cnt_reg       <= '0;
            bad_flag_reg  <= 1'b0;
            bin_out_reg   <= '0;
            bad_digit_reg <= 1'b0;
            ovf_reg       <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                bcd_reg      <= bus.bcd_in;
                bin_reg      <= '0;
                cnt_reg      <= '0;
                bad_flag_reg <= |digit_bad_vec;
            end else if (state_reg == ST_SHIFT) begin
                bcd_reg <= bcd_corr;
                bin_reg <= bin_shift;
                cnt_reg <= cnt_reg + CW'(1);
            end
            // Residual BCD after the final shift is the part of the value above 2^BW.
            if (last_shift) begin
                ovf_reg       <= (bcd_corr != '0) && !bad_flag_reg;
                bin_out_reg   <= bad_flag_reg ? '0 : bin_shift;
                bad_digit_reg <= bad_flag_reg;
            end
        end
    end

    assign bus.busy      = (state_reg == ST_SHIFT);
    assign bus.done      = (state_reg == ST_DONE);
    assign bus.bin_out   = bin_out_reg;
    assign bus.bad_digit = bad_digit_reg;
    assign bus.ovf       = ovf_reg;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Scoreboard bench for bcd_to_bin_seq: BW=8 and BW=10 instances, directed vectors.
module tb_bcd_to_bin_seq;

    typedef struct {
        int bin;
        bit bad;
        bit ovf;
        int acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   nbad = 0;
    exp_t q8[$];
    exp_t q10[$];
    exp_t e8;
    exp_t e10;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bcd_to_bin_seq_if #(.NDIG(3), .BW(8))  if8  ();
    bcd_to_bin_seq_if #(.NDIG(3), .BW(10)) if10 ();

    bcd_to_bin_seq #(.NDIG(3), .BW(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (if8)
    );

    bcd_to_bin_seq #(.NDIG(3), .BW(10)) dut10 (
        .clk (clk),
        .rst (rst),
        .bus (if10)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            nbad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitors: pop and compare whenever a DUT presents done.
    always @(posedge clk) begin
        #1;
        if (if8.done) begin
            if (q8.size() == 0) begin
                chk("dut8_unexpected_done", 1, 0);
            end else begin
                e8 = q8.pop_front();
                $display("dut8 done: bin=%0d bad=%0d ovf=%0d latency=%0d", if8.bin_out, if8.bad_digit, if8.ovf, cyc - e8.acc);
                chk("dut8_bin_out", int'(if8.bin_out), e8.bin);
                chk("dut8_bad_digit", int'(if8.bad_digit), int'(e8.bad));
                chk("dut8_ovf", int'(if8.ovf), int'(e8.ovf));
                chk("dut8_latency", cyc - e8.acc, 8);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (if10.done) begin
            if (q10.size() == 0) begin
                chk("dut10_unexpected_done", 1, 0);
            end else begin
                e10 = q10.pop_front();
                $display("dut10 done: bin=%0d bad=%0d ovf=%0d latency=%0d", if10.bin_out, if10.bad_digit, if10.ovf, cyc - e10.acc);
                chk("dut10_bin_out", int'(if10.bin_out), e10.bin);
                chk("dut10_bad_digit", int'(if10.bad_digit), int'(e10.bad));
                chk("dut10_ovf", int'(if10.ovf), int'(e10.ovf));
                chk("dut10_latency", cyc - e10.acc, 10);
            end
        end
    end

    task automatic issue8(input logic [11:0] b, input int ebin, input bit ebad, input bit eovf);
        @(negedge clk);
        if8.bcd_in = b;
        if8.start  = 1'b1;
        @(posedge clk);
        #1;
        q8.push_back('{ebin, ebad, eovf, cyc});
        chk("dut8_busy_after_accept", int'(if8.busy), 1);
        @(negedge clk);
        if8.start = 1'b0;
    endtask

    task automatic issue10(input logic [11:0] b, input int ebin, input bit ebad, input bit eovf);
        @(negedge clk);
        if10.bcd_in = b;
        if10.start  = 1'b1;
        @(posedge clk);
        #1;
        q10.push_back('{ebin, ebad, eovf, cyc});
        chk("dut10_busy_after_accept", int'(if10.busy), 1);
        @(negedge clk);
        if10.start = 1'b0;
    endtask

    task automatic wait_done8();
        int n = 0;
        while (!if8.done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!if8.done) chk("dut8_done_timeout", 0, 1);
    endtask

    task automatic wait_done10();
        int n = 0;
        while (!if10.done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!if10.done) chk("dut10_done_timeout", 0, 1);
    endtask

    task automatic check_idle8(input string tag);
        chk({tag, "_busy"},      int'(if8.busy), 0);
        chk({tag, "_done"},      int'(if8.done), 0);
        chk({tag, "_bin_out"},   int'(if8.bin_out), 0);
        chk({tag, "_bad_digit"}, int'(if8.bad_digit), 0);
        chk({tag, "_ovf"},       int'(if8.ovf), 0);
    endtask

    initial begin
        int busy_cycles;
        if8.start   = 1'b0;
        if8.bcd_in  = '0;
        if10.start  = 1'b0;
        if10.bcd_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check_idle8("reset");
        chk("reset_dut10_busy", int'(if10.busy), 0);
        chk("reset_dut10_bin_out", int'(if10.bin_out), 0);
        @(negedge clk);
        rst = 1'b0;

        // 255 with busy-duration check: busy for exactly 8 cycles.
        issue8(12'h255, 8'hFF, 1'b0, 1'b0);
        busy_cycles = 1;
        while (if8.busy && busy_cycles < 40) begin
            @(posedge clk);
            #1;
            if (if8.busy) busy_cycles++;
        end
        chk("dut8_busy_cycles", busy_cycles, 8);
        wait_done8();

        issue8(12'h000, 0, 1'b0, 1'b0);   wait_done8();
        issue8(12'h128, 8'h80, 1'b0, 1'b0); wait_done8();
        issue8(12'h256, 8'h00, 1'b0, 1'b1); wait_done8();
        issue8(12'h999, 8'hE7, 1'b0, 1'b1); wait_done8();
        issue8(12'h1A3, 0, 1'b1, 1'b0);   wait_done8();

        // Back-to-back with start held: new operand presented in the DONE cycle.
        @(negedge clk);
        if8.bcd_in = 12'h100;
        if8.start  = 1'b1;
        @(posedge clk);
        #1;
        q8.push_back('{100, 1'b0, 1'b0, cyc});
        wait_done8();
        if8.bcd_in = 12'h042;
        @(posedge clk);
        #1;
        q8.push_back('{42, 1'b0, 1'b0, cyc});
        chk("dut8_b2b_busy", int'(if8.busy), 1);
        @(negedge clk);
        if8.start = 1'b0;
        wait_done8();

        // start pulsed mid-SHIFT must be ignored.
        issue8(12'h128, 8'h80, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        if8.bcd_in = 12'h999;
        if8.start  = 1'b1;
        @(negedge clk);
        if8.start = 1'b0;
        wait_done8();
        repeat (12) @(negedge clk);

        // Reset at SHIFT cycle 4 aborts without done.
        if8.bcd_in = 12'h255;
        if8.start  = 1'b1;
        @(negedge clk);
        if8.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_idle8("abort");
        @(negedge clk);
        rst = 1'b0;
        repeat (14) @(negedge clk);

        issue8(12'h077, 77, 1'b0, 1'b0); wait_done8();

        // rst together with start: rst wins.
        @(negedge clk);
        rst = 1'b1;
        if8.bcd_in = 12'h255;
        if8.start  = 1'b1;
        @(posedge clk);
        #1;
        check_idle8("rst_vs_start");
        @(negedge clk);
        rst = 1'b0;
        if8.start = 1'b0;
        repeat (12) @(negedge clk);

        // Wider output instance.
        issue10(12'h999, 999, 1'b0, 1'b0); wait_done10();
        issue10(12'h256, 256, 1'b0, 1'b0); wait_done10();
        issue10(12'h1A3, 0, 1'b1, 1'b0);   wait_done10();
        issue10(12'h000, 0, 1'b0, 1'b0);   wait_done10();

        repeat (15) @(negedge clk);
        chk("dut8_queue_drained", q8.size(), 0);
        chk("dut10_queue_drained", q10.size(), 0);
        $display("test done: total=%0d bad=%0d", total, nbad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
